// File: rtl/keyed_lock_pkg.sv
// rtl/keyed_lock_pkg.sv - shared types, constants and key-width helper for keyed_lock_pipe
package keyed_lock_pkg;

    // Truth-table bits per MUX4 key LUT (p1..p4).
    localparam int LUT_KEY_BITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        ERR   = 2'd3
    } state_t;

    // Total key length: one XOR bit per data bit plus one truth table per LUT.
    function automatic int key_w(input int data_w, input int num_lut);
        return data_w + LUT_KEY_BITS * num_lut;
    endfunction

endpackage

// File: rtl/mux4_key_lut.sv
// rtl/mux4_key_lut.sv - combinational 4-entry LUT whose truth table comes from key bits
//   sel_i [1:0]  select: 00 -> tbl_i[0] (p1), 01 -> p2, 10 -> p3, 11 -> tbl_i[3] (p4)
//   tbl_i [3:0]  truth table taken from the key register
//   out_o        selected entry
module mux4_key_lut (
    input  logic [1:0] sel_i,
    input  logic [3:0] tbl_i,
    output logic       out_o
);

    assign out_o = tbl_i[sel_i];

endmodule

// File: rtl/keyed_lock_pipe.sv
// rtl/keyed_lock_pipe.sv - 2-stage elastic logic-locking pipe with serially loaded XOR/LUT key
//   Optional feature macro: KEY_PARITY_EN (even-parity check of the loaded key)
//   clk, rst                  clock, synchronous active-high reset
//   key_start_i               clear key/counter, flush pipe, enter LOAD
//   key_bit_i, key_vld_i      serial key, LSB first
//   key_par_i                 expected parity of the whole key (KEY_PARITY_EN only)
//   armed_o, key_err_o        key loaded / parity mismatch (sticky)
//   in_data_i/in_valid_i/in_ready_o     upstream valid/ready stream
//   out_data_o/out_valid_o/out_ready_i  downstream valid/ready stream
//   Requires DATA_W >= 2*NUM_LUT so every LUT has its own two select bits.
module keyed_lock_pipe
    import keyed_lock_pkg::*;
#(
    parameter int DATA_W  = 36,
    parameter int NUM_LUT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_start_i,
    input  logic              key_bit_i,
    input  logic              key_vld_i,
    input  logic              key_par_i,
    output logic              armed_o,
    output logic              key_err_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    localparam int KEY_W = key_w(DATA_W, NUM_LUT);
    localparam int CNT_W = $clog2(KEY_W + 1);

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0]  s1_data_q, s1_data_d;
    logic               s2_vld_q, s2_vld_d;
    logic [DATA_W-1:0]  s2_data_q, s2_data_d;

    logic               s1_adv;
    logic               s2_adv;
    logic [NUM_LUT-1:0] lut_out;
    logic [DATA_W-1:0]  lut_word;

    // ------------------------------------------------------------------
    // Key LUTs: LUT l replaces bit 2l using bits {2l+1, 2l} as select.
    // ------------------------------------------------------------------
    for (genvar l = 0; l < NUM_LUT; l++) begin : g_lut
        mux4_key_lut u_lut (
            .sel_i (s1_data_q[2*l+1 -: 2]),
            .tbl_i (key_q[DATA_W + LUT_KEY_BITS*l +: LUT_KEY_BITS]),
            .out_o (lut_out[l])
        );
    end

    always_comb begin
        lut_word = s1_data_q;
        for (int l = 0; l < NUM_LUT; l++) begin
            lut_word[2*l] = lut_out[l];
        end
    end

    // ------------------------------------------------------------------
    // Key loading FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        if (key_start_i) begin
            state_d = LOAD;
            key_d   = '0;
            cnt_d   = '0;
        end else if (state_q == LOAD && key_vld_i) begin
            for (int i = 0; i < KEY_W; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    key_d[i] = key_bit_i;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(KEY_W - 1)) begin
`ifdef KEY_PARITY_EN
                // key_d already holds the last bit, so this covers the whole key.
                state_d = ((^key_d) != key_par_i) ? ERR : ARMED;
`else
                state_d = ARMED;
`endif
            end
        end
    end

    assign armed_o = (state_q == ARMED);

`ifdef KEY_PARITY_EN
    assign key_err_o = (state_q == ERR);
`else
    logic unused_key_par;
    assign unused_key_par = key_par_i;
    assign key_err_o      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Elastic datapath. Readiness depends only on registered state and
    // out_ready_i, never on in_valid_i.
    // ------------------------------------------------------------------
    assign s2_adv     = !s2_vld_q || out_ready_i;
    assign s1_adv     = !s1_vld_q || s2_adv;
    assign in_ready_o = armed_o && s1_adv;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_data_d = s1_data_q;
        s2_vld_d  = s2_vld_q;
        s2_data_d = s2_data_q;

        // Stage-2 data only changes when a new word moves in, keeping the
        // output stable under backpressure.
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_data_d = lut_word;
            end
        end

        if (in_valid_i && in_ready_o) begin
            s1_vld_d  = 1'b1;
            s1_data_d = in_data_i ^ key_q[DATA_W-1:0];
        end else if (s2_adv) begin
            s1_vld_d = 1'b0;
        end

        // A new key invalidates everything in flight.
        if (key_start_i) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end
    end

    assign out_data_o  = s2_data_q;
    assign out_valid_o = s2_vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            key_q     <= '0;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            cnt_q     <= cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
        end
    end

endmodule
